// File: rtl/frame_difference_pkg.sv
// Shared constants and types for the frame-difference stream pipeline.
package frame_difference_pkg;
  localparam int LATENCY = 3;
  localparam int ROUND   = 128;
  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic {
    BYPASS  = 1'b0,
    PROCESS = 1'b1
  } mode_t;
endpackage

// File: rtl/fd_pixel_core.sv
// One lane of per-pixel arithmetic: abs differences, thresholds, and the
// alpha-blended background update, as three registered stages sharing one enable.
module fd_pixel_core
  import frame_difference_pkg::*;
#(
  parameter int TDATA_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     adv,
  input  logic                     byp,
  input  pixel_t                   fd_th,
  input  pixel_t                   bg_th,
  input  pixel_t                   alpha,
  input  logic [TDATA_WIDTH-1:0]   cur,
  input  logic [TDATA_WIDTH-1:0]   prev,
  input  logic [TDATA_WIDTH-1:0]   bg,
  output logic [3*TDATA_WIDTH-1:0] pix
);
  localparam int W = TDATA_WIDTH;
  typedef logic [W-1:0]   px_t;
  typedef logic [W+7:0]   prod_t;
  typedef logic [W+8:0]   sum_t;

  px_t   d_fd, d_bg, cur1, bg1, cur2, bg2;
  logic  mov2, fg2;
  prod_t pa2;
  sum_t  pb2;

  function automatic px_t absdiff(input px_t a, input px_t b);
    return (a > b) ? a - b : b - a;
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      d_fd <= '0; d_bg <= '0; cur1 <= '0; bg1 <= '0;
      mov2 <= 1'b0; fg2 <= 1'b0; pa2 <= '0; pb2 <= '0; cur2 <= '0; bg2 <= '0;
      pix  <= '0;
    end else if (adv) begin
      d_fd <= absdiff(cur, prev);
      d_bg <= absdiff(cur, bg);
      cur1 <= cur;
      bg1  <= bg;
      // strict greater-than: a difference equal to the threshold is not an event
      mov2 <= prod_t'(d_fd) > prod_t'(fd_th);
      fg2  <= prod_t'(d_bg) > prod_t'(bg_th);
      pa2  <= prod_t'(alpha) * prod_t'(cur1);
      pb2  <= sum_t'(9'd256 - {1'b0, alpha}) * sum_t'(bg1);
      cur2 <= cur1;
      bg2  <= bg1;
      if (byp)
        pix <= {cur2, cur2, cur2};
      else
        pix <= {{W{mov2}}, {W{fg2}},
                mov2 ? bg2 : px_t'((sum_t'(pa2) + pb2 + sum_t'(ROUND)) >> 8)};
    end
  end
endmodule

// File: rtl/frame_difference_stream.sv
// AXI-stream frame differencing / background subtraction, PPC lanes per beat.
// Define FRAME_DIFFERENCE_STREAM_STATS_EN to add the per-frame foreground counter.
module frame_difference_stream
  import frame_difference_pkg::*;
#(
  parameter int TDATA_WIDTH = 8,
  parameter int PPC         = 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  pixel_t                       bg_th,
  input  pixel_t                       fd_th,
  input  pixel_t                       alpha,
  input  logic                         ce,
  input  logic                         force_ready,
  input  logic [3*PPC*TDATA_WIDTH-1:0] s_tdata,
  input  logic                         s_tvalid,
  input  logic                         s_tuser,
  input  logic                         s_tlast,
  output logic                         s_tready,
  output logic [3*PPC*TDATA_WIDTH-1:0] m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tuser,
  output logic                         m_tlast,
  input  logic                         m_tready
`ifdef FRAME_DIFFERENCE_STREAM_STATS_EN
  ,
  output logic [31:0]                  fg_count,
  output logic                         fg_count_valid
`endif
);
  localparam int W = TDATA_WIDTH;

  logic                    adv, acc, byp_in;
  logic [LATENCY:1]        vld_pipe, user_pipe, last_pipe;
  logic [LATENCY-1:1]      byp_pipe;
  mode_t                   mode;
  logic [PPC-1:0][3*W-1:0] pix;

  // the whole pipe moves as one; a held output freezes everything upstream
  assign adv      = !m_tvalid || m_tready || force_ready;
  assign s_tready = adv;
  assign acc      = s_tvalid && adv;
  // a start-of-frame beat already runs in the mode it loads
  assign byp_in   = s_tuser ? !ce : (mode == BYPASS);

  assign m_tvalid = vld_pipe[LATENCY];
  assign m_tuser  = user_pipe[LATENCY];
  assign m_tlast  = last_pipe[LATENCY];
  assign m_tdata  = pix;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe  <= '0;
      user_pipe <= '0;
      last_pipe <= '0;
      byp_pipe  <= '0;
      mode      <= BYPASS;
    end else begin
      if (acc && s_tuser) mode <= ce ? PROCESS : BYPASS;
      if (adv) begin
        vld_pipe  <= {vld_pipe[LATENCY-1:1], s_tvalid};
        user_pipe <= {user_pipe[LATENCY-1:1], s_tvalid && s_tuser};
        last_pipe <= {last_pipe[LATENCY-1:1], s_tvalid && s_tlast};
        byp_pipe  <= {byp_pipe[LATENCY-2:1], byp_in};
      end
    end
  end

  for (genvar i = 0; i < PPC; i++) begin : g_lane
    fd_pixel_core #(.TDATA_WIDTH(W)) u_core (
      .aclk    (aclk),
      .aresetn (aresetn),
      .adv     (adv),
      .byp     (byp_pipe[LATENCY-1]),
      .fd_th   (fd_th),
      .bg_th   (bg_th),
      .alpha   (alpha),
      .cur     (s_tdata[i*3*W +: W]),
      .prev    (s_tdata[i*3*W+W +: W]),
      .bg      (s_tdata[i*3*W+2*W +: W]),
      .pix     (pix[i])
    );
  end

`ifdef FRAME_DIFFERENCE_STREAM_STATS_EN
  logic [31:0] fg_run;
  logic [2:0]  beat_fg;
  logic [32:0] fg_sum;

  always_comb begin
    beat_fg = '0;
    for (int i = 0; i < PPC; i++) beat_fg = beat_fg + 3'(pix[i][2*W-1]);
  end
  assign fg_sum = {1'b0, fg_run} + 33'(beat_fg);

  // only beats the sink takes are counted; dropped beats never reach here
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fg_run         <= '0;
      fg_count       <= '0;
      fg_count_valid <= 1'b0;
    end else begin
      fg_count_valid <= 1'b0;
      if (m_tvalid && m_tready) begin
        if (m_tuser) begin
          fg_count       <= fg_run;
          fg_count_valid <= 1'b1;
          fg_run         <= 32'(beat_fg);
        end else begin
          fg_run <= fg_sum[32] ? '1 : fg_sum[31:0];
        end
      end
    end
  end
`endif
endmodule
